// File: rtl/rx_stream_arbiter.sv
// Round-robin arbiter sharing one output word path between NMODULES FWFT streams, with per-source word counters.
// Latency: 1 cycle from input pop to out_valid; each regrant costs one idle cycle.
// Backpressure: in_ready is withheld while the output register is full and not draining; stalls never rotate the grant.
module rx_stream_arbiter #(
    parameter int NMODULES  = 4,
    parameter int LENGTH    = 128,
    parameter int MAX_BURST = 16,
    parameter int SRC_W     = (NMODULES > 1) ? $clog2(NMODULES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NMODULES-1:0]    in_valid,
    input  logic [NMODULES*LENGTH-1:0] in_data,
    output logic [NMODULES-1:0]    in_ready,
    input  logic [NMODULES-1:0]    enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LENGTH-1:0]      out_data,
    output logic [SRC_W-1:0]       out_src,
    input  logic                   clear_counts,
    output logic [NMODULES*32-1:0] word_count
);

    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    grant_q, grant_d;
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                out_valid_q;
    logic [LENGTH-1:0]   out_data_q;
    logic [SRC_W-1:0]    out_src_q;
    logic [31:0]         cnt_q [NMODULES];

    logic [NMODULES-1:0] req;
    logic [NMODULES-1:0] gsel;
    logic [LENGTH-1:0]   g_data;
    logic                g_valid, g_en;
    logic                space, xfer, hs, hit;
    logic [SRC_W-1:0]    hit_idx, grant_inc;

    // Decode the granted stream and find the first requester at or after ptr
    always_comb begin
        req     = in_valid & enable;
        gsel    = '0;
        g_data  = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < NMODULES; k++) begin
            if (grant_q == SRC_W'(k)) begin
                gsel[k] = 1'b1;
                g_data  = in_data[k*LENGTH +: LENGTH];
            end
        end
        for (int i = 0; i < NMODULES; i++) begin
            for (int k = 0; k < NMODULES; k++) begin
                if (!hit && req[k] && (k == ((int'(ptr_q) + i) % NMODULES))) begin
                    hit     = 1'b1;
                    hit_idx = SRC_W'(k);
                end
            end
        end
        g_valid   = |(in_valid & gsel);
        g_en      = |(enable & gsel);
        grant_inc = (grant_q == SRC_W'(NMODULES - 1)) ? '0 : grant_q + 1'b1;
        space     = ~out_valid_q | out_ready;
        in_ready  = ((state_q == GRANT) && g_en && space) ? gsel : '0;
        xfer      = |(in_valid & in_ready);
        hs        = out_valid_q & out_ready;
    end

    // Arbitration FSM next state: grant on a search hit, release on burst end, empty source or mask drop
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    grant_d = hit_idx;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!g_en) begin
                    state_d = IDLE;
                    ptr_d   = grant_inc;
                end else if (space) begin
                    if (!g_valid || (burst_q == BURST_LAST)) begin
                        state_d = IDLE;
                        ptr_d   = grant_inc;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

    // Output register: load on transfer, empty on handshake without a new word, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= g_data;
            out_src_q   <= grant_q;
        end else if (hs) begin
            out_valid_q <= 1'b0;
        end
    end

    // Per-source delivered word counters; clear takes priority over a coincident handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NMODULES; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NMODULES; k++) begin
                if (clear_counts) begin
                    cnt_q[k] <= '0;
                end else if (hs && (out_src_q == SRC_W'(k))) begin
                    cnt_q[k] <= cnt_q[k] + 32'd1;
                end
            end
        end
    end

    // Flatten counters onto the status bus
    always_comb begin
        word_count = '0;
        for (int k = 0; k < NMODULES; k++) word_count[k*32 +: 32] = cnt_q[k];
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
